multiplicador_secuencial: RTL
=============================

// Module: multiplicador_secuencial
// PURPOSE
//  Sequential shift-and-add NxN multiplier; successor to the lab's combinational array
//  multiplier. One partial product is accumulated per clock, trading latency for area.
//  Start/done handshake so the calculator FSM can launch an operation and wait for it.
//  2N-bit product returned as low half R and high half Of, plus a 1-bit overflow flag.
// PARAMETERS
//  N  4  operand width in bits (N >= 2); product is 2N bits
// PORTS
//  clk    in   1  single system clock, rising edge
//  rst_n  in   1  asynchronous, active-low reset
//  start  in   1  request; sampled on the rising edge only while busy=0
//  x      in   N  multiplicand; captured on the accepting edge
//  y      in   N  multiplier; captured on the accepting edge
//  busy   out  1  high while the multiply is computing (CALC state)
//  done   out  1  one-cycle pulse; R/Of/ovf are valid from this cycle on
//  R      out  N  low N bits of the product
//  Of     out  N  high N bits of the product
//  ovf    out  1  1 when the product does not fit in N bits (see arithmetic rules)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, R=0, Of=0, ovf=0; all internal regs 0.
//  States:
//   - IDLE: start=1 captures x and y, clears acc (2N bits) and cnt, goes to CALC.
//   - CALC: busy=1. Each edge: if ymul[0] then acc += xmul<<cnt; ymul>>=1; cnt++.
//     Leaves after exactly N CALC edges (cnt==N-1 on the last one) and loads R, Of, ovf.
//   - DONE: done=1 for exactly one cycle, busy=0. start=1 here is accepted exactly as in IDLE
//     (back-to-back operation); otherwise the block returns to IDLE.
//  Latency: start accepted at edge 0; busy=1 after edges 0..N-1; R/Of/ovf/done updated at
//   edge N; done falls at edge N+1. One operation takes N+1 cycles.
//  Start rules:
//   - start while busy=1 is ignored; x and y may change freely while busy=1.
//   - A start held high in IDLE launches one op; if still high in DONE, it launches the next.
//  Outputs R, Of and ovf hold their value until the next result load; they never glitch
//   during CALC.
//  Arithmetic: accumulator is 2N bits wide, so no carry is lost. Unsigned ovf = |Of.
//  Zero operands still take the full N cycles (no early exit): fixed latency.
//  Reset mid-operation (CALC or DONE) aborts the op with no done pulse and clears outputs to 0.
// CONFIGURATION
//  MULT_SIGNED_EN (undefined, default): x and y are unsigned; {Of,R} = x*y; ovf = |Of.
//  MULT_SIGNED_EN defined: x and y are two's complement.
//   - The capture edge stores magnitudes |x| and |y| in N bits (-2^(N-1) maps to 2^(N-1))
//     plus sgn = x[N-1]^y[N-1].
//   - CALC is unchanged. At the result load, acc is negated when sgn=1; then {Of,R} = that value.
//   - ovf = 1 when bits [2N-1:N-1] of the result are not all equal
//     (the result is not representable as an N-bit signed value).
//   - Latency is identical in both builds.
// TESTING (N=4)
//  1. Unsigned: x=3, y=2, start 1 cycle -> busy 4 cycles; done after edge 4;
//     R=6, Of=0, ovf=0.
//  2. Unsigned max: x=15, y=15 -> {Of,R}=0xE1 (Of=0xE, R=0x1), ovf=1.
//     Then x=0, y=9 -> R=0, Of=0, ovf=0, still 5-cycle latency.
//  3. Busy ignore: start x=5,y=5, pulse start with x=1,y=1 during busy -> result 25
//     (Of=1,R=9), single done pulse.
//  4. Back-to-back: start held high across DONE with x=2,y=7 -> done pulses every 5 cycles,
//     R=0xE each time.
//  5. Reset mid-op: start x=7,y=7, drop rst_n after 2 CALC edges -> outputs 0 immediately,
//     no done; the next op x=1,y=1 gives R=1.
//  6. MULT_SIGNED_EN:
//     - x=-3 (0xD), y=5 -> {Of,R}=0xF1 (-15), ovf=1.
//     - x=-8, y=-8 -> 0x40, ovf=1.
//     - x=-2, y=3 -> 0xFA, ovf=0.

Source files
------------

// File: rtl/multiplicador_secuencial.sv
// multiplicador_secuencial: NxN shift-and-add multiplier, one partial product per clock.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module multiplicador_secuencial #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] R,
   output logic [N-1:0] Of,
   output logic         ovf
);
   localparam int CW = (N > 2) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;
   logic [N-1:0] xmul, ymul, xc, yc;
   logic [2*N-1:0] acc, acc_nx, res;
   logic [CW-1:0] cnt;
   logic accept, last, ovf_nx;
`ifdef MULT_SIGNED_EN
   logic sgn;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      accept = start && (state != CALC);
      last = (state == CALC) && (cnt == CW'(N - 1));
      state_nx = accept ? CALC : last ? DONE : (state == DONE) ? IDLE : state;
      acc_nx = acc + (ymul[0] ? ({{N{1'b0}}, xmul} << cnt) : '0);
`ifdef MULT_SIGNED_EN
      // -2^(N-1) negates to itself, which read unsigned is the correct magnitude
      xc = x[N-1] ? -x : x;
      yc = y[N-1] ? -y : y;
      res = sgn ? -acc_nx : acc_nx;
      ovf_nx = ~(&res[2*N-1:N-1] | ~|res[2*N-1:N-1]);
`else
      xc = x;
      yc = y;
      res = acc_nx;
      ovf_nx = |res[2*N-1:N];
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         xmul <= '0;
         ymul <= '0;
         acc <= '0;
         cnt <= '0;
         R <= '0;
         Of <= '0;
         ovf <= 1'b0;
`ifdef MULT_SIGNED_EN
         sgn <= 1'b0;
`endif
      end else if (accept) begin
         xmul <= xc;
         ymul <= yc;
         acc <= '0;
         cnt <= '0;
`ifdef MULT_SIGNED_EN
         sgn <= x[N-1] ^ y[N-1];
`endif
      end else if (state == CALC) begin
         acc <= acc_nx;
         ymul <= ymul >> 1;
         cnt <= cnt + 1'b1;
         if (last) begin
            {Of, R} <= res;
            ovf <= ovf_nx;
         end
      end
   assign busy = (state == CALC);
   assign done = (state == DONE);
endmodule
